// File: rtl/edge_trigger_pkg.sv
// Shared types and constants for the edge_trigger block: control FSM states
// and the pipeline latency from the monitored input to the history register.
package edge_trigger_pkg;

  typedef enum logic [0:0] {
    PRIME = 1'b0,
    ARMED = 1'b1
  } state_e;

  localparam int unsigned MAX_SYNC_STAGES = 3;
  localparam int unsigned CNT_W           = 3;

  // Clocks needed after reset before in_q and in_d both hold real samples.
  function automatic int unsigned prime_latency(input int unsigned sync_stages);
    return 32'd2 + sync_stages;
  endfunction

endpackage

// File: rtl/edge_trigger_sync.sv
// Optional input synchronizer: a chain of STAGES reset-to-zero flops, or a
// plain wire when STAGES is 0.
module edge_trigger_sync #(
  parameter int unsigned STAGES = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  generate
    if (STAGES == 0) begin : g_pass
      logic unused_clk_reset;
      assign unused_clk_reset = clk ^ reset;
      assign q = d;
    end else begin : g_chain
      logic [STAGES-1:0] chain;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          chain <= '0;
        end else begin
          chain[0] <= d;
          for (int i = 1; i < STAGES; i++) begin
            chain[i] <= chain[i-1];
          end
        end
      end

      assign q = chain[STAGES-1];
    end
  endgenerate

endmodule

// File: rtl/edge_trigger.sv
// Polarity-selectable edge detector: emits a registered one-cycle tick for
// each edge of in matching en, suppressed until the pipeline has refilled.
module edge_trigger
  import edge_trigger_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic in,
  input  logic en,
  output logic tick
);

  localparam int unsigned       LATENCY = prime_latency(SYNC_STAGES);
  localparam logic [CNT_W-1:0]  LAST    = CNT_W'(LATENCY - 1);

  logic              sync_out;
  logic              in_q;
  logic              in_d;
  logic              detect;
  state_e            state;
  logic [CNT_W-1:0]  prime_cnt;

  edge_trigger_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (in),
    .q     (sync_out)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_q <= 1'b0;
      in_d <= 1'b0;
    end else begin
      in_q <= sync_out;
      in_d <= in_q;
    end
  end

  // en is used live, so a polarity change landing with an input change
  // classifies that change under the new polarity.
  assign detect = (in_q == en) && (in_d != en);

  // Stay in PRIME until both history registers hold post-reset samples, so a
  // level present at reset release cannot look like an edge from zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= PRIME;
      prime_cnt <= '0;
    end else begin
      case (state)
        PRIME: begin
          if (prime_cnt == LAST) begin
            state <= ARMED;
          end else begin
            prime_cnt <= prime_cnt + 1'b1;
          end
        end
        ARMED: state <= ARMED;
        default: state <= PRIME;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick <= 1'b0;
    end else begin
      tick <= (state == ARMED) && detect;
    end
  end

endmodule

// File: tb/tb_edge_trigger.sv
// Scoreboard bench for edge_trigger: one instance without synchronizer and
// one with two stages share the same stimulus and are checked independently.
module tb_edge_trigger;

  logic clk = 1'b0;
  logic reset;
  logic in;
  logic en;
  logic tick0;
  logic tick2;

  int cyc   = 0;
  int tests = 0;
  int fails = 0;
  int q0[$];
  int q2[$];
  int exp0;
  int exp2;

  logic en_list [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  edge_trigger #(.SYNC_STAGES(0)) dut0 (
    .clk   (clk),
    .reset (reset),
    .in    (in),
    .en    (en),
    .tick  (tick0)
  );

  edge_trigger #(.SYNC_STAGES(2)) dut2 (
    .clk   (clk),
    .reset (reset),
    .in    (in),
    .en    (en),
    .tick  (tick2)
  );

  task check_output(input string name, input logic actual, input logic expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: tick=%0b, expected %0b", name, actual, expected);
    end
  endtask

  // Expected tick cycles: change after edge k shows up at edge k+2 (no sync)
  // or k+4 (two sync stages).
  task apply_stimulus(input logic in_v, input logic en_v, input bit expect_tick, input int hold);
    @(posedge clk);
    #1;
    in = in_v;
    en = en_v;
    if (expect_tick) begin
      q0.push_back(cyc + 2);
      q2.push_back(cyc + 4);
    end
    repeat (hold - 1) @(posedge clk);
  endtask

  always @(negedge clk) begin
    if (tick0 !== 1'b0) begin
      tests++;
      if (q0.size() == 0) begin
        fails++;
        $display("[TB] FAIL tick0_unexpected: tick=%0b at cycle %0d, expected no tick", tick0, cyc);
      end else begin
        exp0 = q0.pop_front();
        if (exp0 != cyc) begin
          fails++;
          $display("[TB] FAIL tick0_timing: tick at cycle %0d, expected cycle %0d", cyc, exp0);
        end
      end
    end
    if (tick2 !== 1'b0) begin
      tests++;
      if (q2.size() == 0) begin
        fails++;
        $display("[TB] FAIL tick2_unexpected: tick=%0b at cycle %0d, expected no tick", tick2, cyc);
      end else begin
        exp2 = q2.pop_front();
        if (exp2 != cyc) begin
          fails++;
          $display("[TB] FAIL tick2_timing: tick at cycle %0d, expected cycle %0d", cyc, exp2);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation still running at time %0t, expected to have finished", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b0;
    in    = 1'b0;
    en    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_output("reset_tick0", tick0, 1'b0);
    check_output("reset_tick2", tick2, 1'b0);
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (8) @(posedge clk);

    // Rising edge held two cycles, falling edge ignored.
    apply_stimulus(1'b1, 1'b1, 1'b1, 2);
    apply_stimulus(1'b0, 1'b1, 1'b0, 6);

    // Falling-edge mode; the rise that arrives with the en switch is ignored.
    apply_stimulus(1'b1, 1'b0, 1'b0, 6);
    apply_stimulus(1'b0, 1'b0, 1'b1, 2);
    apply_stimulus(1'b1, 1'b0, 1'b0, 6);

    foreach (en_list[i]) begin
      apply_stimulus(~en_list[i], en_list[i], 1'b0, 1);
      apply_stimulus(en_list[i], en_list[i], 1'b1, 2);
      apply_stimulus(~en_list[i], en_list[i], 1'b0, 6);
    end

    // High level through reset release, then en toggles with in stable.
    @(posedge clk);
    #1;
    reset = 1'b0;
    in    = 1'b1;
    en    = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    repeat (10) @(posedge clk);
    apply_stimulus(1'b1, 1'b0, 1'b0, 3);
    apply_stimulus(1'b1, 1'b1, 1'b0, 8);

    // Single-cycle pulse.
    apply_stimulus(1'b0, 1'b1, 1'b0, 8);
    apply_stimulus(1'b1, 1'b1, 1'b1, 1);
    apply_stimulus(1'b0, 1'b1, 1'b0, 8);

    // Reset during a tick, then an edge right at release.
    @(posedge clk);
    #1 in = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_output("pre_reset_tick0", tick0, 1'b1);
    reset = 1'b0;
    #1;
    check_output("reset_kill_tick0", tick0, 1'b0);
    check_output("reset_kill_tick2", tick2, 1'b0);
    in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    in    = 1'b1;
    repeat (10) @(posedge clk);
    apply_stimulus(1'b0, 1'b1, 1'b0, 6);
    apply_stimulus(1'b1, 1'b1, 1'b1, 8);
    repeat (4) @(posedge clk);

    tests++;
    if (q0.size() != 0) begin
      fails++;
      $display("[TB] FAIL tick0_missing: %0d ticks outstanding, expected 0", q0.size());
    end
    tests++;
    if (q2.size() != 0) begin
      fails++;
      $display("[TB] FAIL tick2_missing: %0d ticks outstanding, expected 0", q2.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
